mult_t_c1x2_16x16: RTL and testbench

Runtime-reconfigurable 16x16 multiplier for the PIRDSP datapath. It produces its result as two 32-bit partial vectors plus a 2-bit carry side-band, so the downstream adder/accumulator in the DSP tile can add them. In reduced-precision modes it computes sums of two products, either one 16x8 lane or two 8x4 lanes, with per-operand signedness.

---
 rtl/mult_t_c1x2_16x16_pkg.sv | 15 +
 rtl/mult_t_c1x2_16x16_signed_submul.sv | 28 ++
 rtl/mult_t_c1x2_16x16.sv | 94 +++++++++
 tb/tb_mult_t_c1x2_16x16.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/mult_t_c1x2_16x16_pkg.sv
// Shared definitions for the reconfigurable 16x16 multiplier: mode encodings
// and the bit positions where the reduced-precision lanes start and end.
package mult_t_c1x2_16x16_pkg;

  typedef enum logic [2:0] {
    MODE_16X16    = 3'd0,
    MODE_SUM_16X8 = 3'd1,
    MODE_SUM_8X4  = 3'd2
  } mode_e;

  localparam int LANE_LO  = 8;
  localparam int LANE_MID = 20;
  localparam int LANE_TOP = 32;

endpackage

// File: rtl/mult_t_c1x2_16x16_signed_submul.sv
// N x M multiplier whose operands are each widened by one bit, either sign or
// zero, so one instance covers all four signedness combinations.
module signed_submul #(
  parameter int N = 16,
  parameter int M = 8
) (
  input  logic [N-1:0]            x,
  input  logic [M-1:0]            y,
  input  logic                    x_signed,
  input  logic                    y_signed,
  output logic signed [N+M+1:0]   p
);

  logic               x_top;
  logic               y_top;
  logic signed [N+M+1:0] x_wide;
  logic signed [N+M+1:0] y_wide;

  assign x_top = x_signed & x[N-1];
  assign y_top = y_signed & y[M-1];

  // Both operands are widened to the full product width so the multiply is
  // exact and carries no implicit width conversion.
  assign x_wide = {{(M+2){x_top}}, x};
  assign y_wide = {{(N+2){y_top}}, y};
  assign p      = x_wide * y_wide;

endmodule

// File: rtl/mult_t_c1x2_16x16.sv
// Runtime-reconfigurable 16x16 multiplier producing two partial vectors plus a
// per-lane carry side-band; purely combinational.
module mult_t_c1x2_16x16
  import mult_t_c1x2_16x16_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] a,
  input  logic [15:0] b,
  input  logic        a_sign,
  input  logic        b_sign,
  input  logic [2:0]  mode,
  output logic [31:0] result_0,
  output logic [31:0] result_1,
  output logic [1:0]  result_SIDM_carry
);

  logic               is_full;
  logic               lo_b_sign;
  logic [15:0]        hi_a;
  logic signed [25:0] p16_lo;
  logic signed [25:0] p16_hi;
  logic signed [13:0] p8_l0a;
  logic signed [13:0] p8_l0b;
  logic signed [13:0] p8_l1a;
  logic signed [13:0] p8_l1b;
  logic [24:0]        sum_16x8;
  logic [12:0]        sum_lane0;
  logic [12:0]        sum_lane1;
  logic [31:0]        res0;
  logic [31:0]        res1;
  logic [1:0]         carry;
  logic               unused_ok;

  // The two 16x8 multipliers are shared between mode 0 and mode 1; in mode 0
  // the low byte of b is always unsigned and both halves use a[15:0].
  assign is_full   = (mode == MODE_16X16);
  assign lo_b_sign = is_full ? 1'b0 : b_sign;
  assign hi_a      = is_full ? a[15:0] : a[31:16];

  signed_submul #(.N(16), .M(8)) u_mul16_lo (
    .x(a[15:0]), .y(b[7:0]), .x_signed(a_sign), .y_signed(lo_b_sign), .p(p16_lo)
  );
  signed_submul #(.N(16), .M(8)) u_mul16_hi (
    .x(hi_a), .y(b[15:8]), .x_signed(a_sign), .y_signed(b_sign), .p(p16_hi)
  );
  signed_submul #(.N(8), .M(4)) u_mul8_l0a (
    .x(a[7:0]), .y(b[3:0]), .x_signed(a_sign), .y_signed(b_sign), .p(p8_l0a)
  );
  signed_submul #(.N(8), .M(4)) u_mul8_l0b (
    .x(a[23:16]), .y(b[11:8]), .x_signed(a_sign), .y_signed(b_sign), .p(p8_l0b)
  );
  signed_submul #(.N(8), .M(4)) u_mul8_l1a (
    .x(a[15:8]), .y(b[7:4]), .x_signed(a_sign), .y_signed(b_sign), .p(p8_l1a)
  );
  signed_submul #(.N(8), .M(4)) u_mul8_l1b (
    .x(a[31:24]), .y(b[15:12]), .x_signed(a_sign), .y_signed(b_sign), .p(p8_l1b)
  );

  assign sum_16x8  = p16_lo[24:0] + p16_hi[24:0];
  assign sum_lane0 = p8_l0a[12:0] + p8_l0b[12:0];
  assign sum_lane1 = p8_l1a[12:0] + p8_l1b[12:0];

  always_comb begin
    res0  = '0;
    res1  = '0;
    carry = '0;
    case (mode)
      MODE_16X16: begin
        res0 = {{6{p16_lo[25]}}, p16_lo};
        res1 = {p16_hi[23:0], {LANE_LO{1'b0}}};
      end
      MODE_SUM_16X8: begin
        {carry[1], res0} = {sum_16x8, {LANE_LO{1'b0}}};
      end
      MODE_SUM_8X4: begin
        {carry[0], res0[LANE_MID-1:0]}        = {sum_lane0, {LANE_LO{1'b0}}};
        {carry[1], res0[LANE_TOP-1:LANE_MID]} = sum_lane1;
      end
      default: begin
      end
    endcase
  end

  assign result_0          = res0;
  assign result_1          = res1;
  assign result_SIDM_carry = carry;

  // Clock and reset exist only for tile uniformity; truncated product bits
  // above each field are intentionally dropped.
  assign unused_ok = ^{clk, reset_n, p16_hi[25:24],
                       p8_l0a[13], p8_l0b[13], p8_l1a[13], p8_l1b[13]};

endmodule

// File: tb/tb_mult_t_c1x2_16x16.sv
// Self-checking bench: directed vectors plus a randomized sweep checked against
// an arithmetic model of the consumer contract.
module tb_mult_t_c1x2_16x16;

  logic        clk;
  logic        reset_n;
  logic [31:0] a;
  logic [15:0] b;
  logic        a_sign;
  logic        b_sign;
  logic [2:0]  mode;
  logic [31:0] result_0;
  logic [31:0] result_1;
  logic [1:0]  result_SIDM_carry;

  int checks;
  int failures;

  mult_t_c1x2_16x16 dut (
    .clk(clk),
    .reset_n(reset_n),
    .a(a),
    .b(b),
    .a_sign(a_sign),
    .b_sign(b_sign),
    .mode(mode),
    .result_0(result_0),
    .result_1(result_1),
    .result_SIDM_carry(result_SIDM_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Interprets the low w bits of v as signed or unsigned.
  function automatic longint sx(input longint v, input int w, input bit s);
    longint masked;
    masked = v & ((longint'(1) << w) - 1);
    if (s && masked[w-1]) return masked - (longint'(1) << w);
    return masked;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic [31:0] av, input logic [15:0] bv,
                               input logic as, input logic bs, input logic [2:0] m);
    @(negedge clk);
    a      = av;
    b      = bv;
    a_sign = as;
    b_sign = bs;
    mode   = m;
    #1;
  endtask

  // Checks the current outputs against the consumer contract for the
  // currently applied inputs.
  task automatic checkContract();
    longint      prod;
    longint      p;
    longint      l0;
    longint      l1;
    logic [31:0] sum32;
    logic [32:0] sum33;
    logic [20:0] sum21;
    logic [12:0] sum13;
    case (mode)
      3'd0: begin
        prod  = sx(longint'(a[15:0]), 16, a_sign) * sx(longint'(b), 16, b_sign);
        sum32 = result_0 + result_1;
        checkOutput("rnd_m0_sum", 64'(sum32), 64'(prod[31:0]));
      end
      3'd1: begin
        p = sx(longint'(a[15:0]), 16, a_sign) * sx(longint'(b[7:0]), 8, b_sign)
          + sx(longint'(a[31:16]), 16, a_sign) * sx(longint'(b[15:8]), 8, b_sign);
        sum33 = {result_SIDM_carry[1], result_0} + {1'b0, result_1};
        checkOutput("rnd_m1_sum", 64'(sum33[32:8]), 64'(p[24:0]));
      end
      3'd2: begin
        l0 = sx(longint'(a[7:0]), 8, a_sign) * sx(longint'(b[3:0]), 4, b_sign)
           + sx(longint'(a[23:16]), 8, a_sign) * sx(longint'(b[11:8]), 4, b_sign);
        l1 = sx(longint'(a[15:8]), 8, a_sign) * sx(longint'(b[7:4]), 4, b_sign)
           + sx(longint'(a[31:24]), 8, a_sign) * sx(longint'(b[15:12]), 4, b_sign);
        sum21 = {result_SIDM_carry[0], result_0[19:0]} + {1'b0, result_1[19:0]};
        sum13 = {result_SIDM_carry[1], result_0[31:20]} + {1'b0, result_1[31:20]};
        checkOutput("rnd_m2_lane0", 64'(sum21[20:8]), 64'(l0[12:0]));
        checkOutput("rnd_m2_lane1", 64'(sum13), 64'(l1[12:0]));
      end
      default: begin
        checkOutput("rnd_rsv_all", 64'({result_SIDM_carry, result_0, result_1}), 64'd0);
      end
    endcase
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    a        = '0;
    b        = '0;
    a_sign   = 1'b0;
    b_sign   = 1'b0;
    mode     = '0;

    // Outputs follow inputs even while reset is asserted.
    applyStimulus(32'h0000_0003, 16'h0005, 1'b0, 1'b0, 3'd0);
    checkOutput("rst_m0_sum", 64'(result_0 + result_1), 64'd15);
    checkOutput("rst_m0_carry", 64'(result_SIDM_carry), 64'd0);
    reset_n = 1'b1;

    applyStimulus(32'h0000_FFFF, 16'hFFFF, 1'b0, 1'b0, 3'd0);
    checkOutput("m0_uu_sum", 64'(result_0 + result_1), 64'hFFFE_0001);
    checkOutput("m0_uu_carry", 64'(result_SIDM_carry), 64'd0);

    applyStimulus(32'hFFFF_FFFF, 16'h8000, 1'b1, 1'b1, 3'd0);
    checkOutput("m0_ss_sum", 64'(result_0 + result_1), 64'h0000_8000);

    applyStimulus(32'h0002_0003, 16'h0504, 1'b0, 1'b0, 3'd1);
    checkOutput("m1_uu_r0", 64'(result_0), 64'h0000_1600);
    checkOutput("m1_uu_r1", 64'(result_1), 64'd0);
    checkOutput("m1_uu_carry", 64'(result_SIDM_carry), 64'd0);

    applyStimulus(32'h8000_8000, 16'h8080, 1'b1, 1'b1, 3'd1);
    checkOutput("m1_ss_r0", 64'(result_0), 64'h8000_0000);
    checkOutput("m1_ss_carry", 64'(result_SIDM_carry), 64'd0);

    applyStimulus(32'h807F_807F, 16'h8787, 1'b1, 1'b1, 3'd2);
    checkOutput("m2_ss_r0", 64'(result_0), 64'h8006_F200);
    checkOutput("m2_ss_r1", 64'(result_1), 64'd0);
    checkOutput("m2_ss_carry", 64'(result_SIDM_carry), 64'd0);

    applyStimulus(32'hFFFF_FFFF, 16'hFFFF, 1'b0, 1'b0, 3'd2);
    checkOutput("m2_uu_r0", 64'(result_0), 64'hDE2D_E200);
    checkOutput("m2_uu_carry", 64'(result_SIDM_carry), 64'd3);

    applyStimulus($urandom, 16'($urandom), 1'b1, 1'b0, 3'd3);
    checkOutput("m3_r0", 64'(result_0), 64'd0);
    checkOutput("m3_r1", 64'(result_1), 64'd0);
    checkOutput("m3_carry", 64'(result_SIDM_carry), 64'd0);

    for (int m = 0; m < 3; m++) begin
      for (int s = 0; s < 4; s++) begin
        for (int i = 0; i < 100; i++) begin
          applyStimulus($urandom, 16'($urandom), s[1], s[0], 3'(m));
          checkContract();
        end
      end
    end

    for (int m = 3; m < 8; m++) begin
      for (int i = 0; i < 10; i++) begin
        applyStimulus($urandom, 16'($urandom), 1'($urandom), 1'($urandom), 3'(m));
        checkContract();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
